// File: rtl/pc_fetch_scp_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_scp_if
// Purpose : bundles the control inputs and fetch outputs of the single-cycle
//           MIPS program-counter / fetch stage.
// Modports:
//   master - decode/control side: drives stall, halt, branch, br_imm, jump,
//            j_target, jr, jr_addr; observes pc, pc_plus4, ima, fetch_valid,
//            halted, fault, fetch_cnt.
//   slave  - the fetch stage itself (pc_fetch_scp), the mirror of master.
// Signals :
//   stall       hold PC this cycle
//   halt        decoder saw a halt instruction; stop fetching
//   branch      conditional branch taken
//   br_imm      signed word offset of the branch
//   jump        j / jal
//   j_target    26-bit jump index field
//   jr          jump register
//   jr_addr     register value for jr
//   pc          current PC (byte address)
//   pc_plus4    PC + 4 (link value)
//   ima         instruction-memory word address, pc[IM_AW+1:2]
//   fetch_valid 1 while running
//   halted      1 while halted
//   fault       1 while in the bounds-fault state (0 when the check is absent)
//   fetch_cnt   saturating count of completed fetches
// ---------------------------------------------------------------------------
interface pc_fetch_scp_if #(
    parameter int WL    = 32,
    parameter int IM_AW = 6
);
    logic              stall;
    logic              halt;
    logic              branch;
    logic [15:0]       br_imm;
    logic              jump;
    logic [25:0]       j_target;
    logic              jr;
    logic [WL-1:0]     jr_addr;

    logic [WL-1:0]     pc;
    logic [WL-1:0]     pc_plus4;
    logic [IM_AW-1:0]  ima;
    logic              fetch_valid;
    logic              halted;
    logic              fault;
    logic [WL-1:0]     fetch_cnt;

    modport master (
        output stall, halt, branch, br_imm, jump, j_target, jr, jr_addr,
        input  pc, pc_plus4, ima, fetch_valid, halted, fault, fetch_cnt
    );

    modport slave (
        input  stall, halt, branch, br_imm, jump, j_target, jr, jr_addr,
        output pc, pc_plus4, ima, fetch_valid, halted, fault, fetch_cnt
    );
endinterface

// File: rtl/pc_fetch_scp.sv
// ---------------------------------------------------------------------------
// pc_fetch_scp
// Purpose : program-counter / fetch stage of a single-cycle MIPS datapath.
//           Holds the PC, selects the next PC (sequential, branch, jump,
//           jump-register), drives the instruction-memory word address,
//           tracks run/halt state and counts completed fetches.
// Ports   :
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - pc_fetch_scp_if.slave (control inputs, PC/fetch outputs)
// Params  :
//   WL       - datapath / PC width (must match the interface, >= 32)
//   IM_AW    - instruction-memory word-address width (must match interface)
//   RESET_PC - word-aligned byte address loaded on reset
// Config  :
//   PC_BOUNDS_CHECK_EN - when defined, a next PC that falls outside the
//   instruction memory is not taken; the stage enters an absorbing FAULT
//   state instead. When undefined, ima simply truncates the PC so fetches
//   wrap inside the memory, and fault is tied low.
// ---------------------------------------------------------------------------
module pc_fetch_scp #(
    parameter int              WL       = 32,
    parameter int              IM_AW    = 6,
    parameter logic [WL-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    pc_fetch_scp_if.slave    bus
);

`ifdef PC_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1
    } state_t;
`endif

    // Upper bits of a jump target come from PC+4; only bits above the 28-bit
    // region addressed by {j_target, 2'b00} are kept.
    localparam logic [WL-1:0] JUMP_REGION_MASK = {{(WL-28){1'b1}}, 28'h0};

    state_t           state;
    logic [WL-1:0]    pc_q;
    logic [WL-1:0]    fetch_cnt_q;
    logic             fetch_valid_q;
    logic             halted_q;
    logic             fault_q;

    logic [WL-1:0]    pc_plus4;
    logic [WL-1:0]    jr_target;
    logic [WL-1:0]    jump_target;
    logic [WL-1:0]    branch_target;
    logic [WL-1:0]    next_pc;

    // ------------------------------------------------------------------
    // Datapath: PC+4 and the candidate targets, all mod 2^WL.
    // ------------------------------------------------------------------
    assign pc_plus4      = pc_q + WL'(4);
    // Masking rather than slicing clears the two byte-offset bits of the
    // register value while keeping every bit of jr_addr in use.
    assign jr_target     = bus.jr_addr & ~WL'(3);
    assign jump_target   = (pc_plus4 & JUMP_REGION_MASK)
                         | {{(WL-28){1'b0}}, bus.j_target, 2'b00};
    assign branch_target = pc_plus4
                         + {{(WL-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};

    // Redirect priority: jr > jump > branch > sequential. Halt and stall are
    // resolved in the state register since they also steer the FSM.
    always_comb begin
        // NOTE: assigning a default before any conditional keeps every path
        // driven, so no latch is inferred for next_pc.
        next_pc = pc_plus4;
        if (bus.jr) begin
            next_pc = jr_target;
        end else if (bus.jump) begin
            next_pc = jump_target;
        end else if (bus.branch) begin
            next_pc = branch_target;
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    logic next_pc_out_of_im;
    assign next_pc_out_of_im = |next_pc[WL-1:IM_AW+2];
`endif

    // ------------------------------------------------------------------
    // State register: FSM, PC and fetch counter in one clocked process.
    // Outputs fetch_valid / halted / fault are registered alongside the
    // state so they change exactly with it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous) and is
        // checked first, so it overrides halt, fault and any redirect.
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state         <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_cnt_q   <= '0;
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.halt) begin
                        // Halt beats stall, redirects and the bounds check.
                        state         <= ST_HALTED;
                        fetch_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else if (bus.stall) begin
                        // PC and counter hold.
                    end
`ifdef PC_BOUNDS_CHECK_EN
                    else if (next_pc_out_of_im) begin
                        // The offending PC is never loaded; PC keeps the
                        // address of the last legal fetch.
                        state         <= ST_FAULT;
                        fetch_valid_q <= 1'b0;
                        fault_q       <= 1'b1;
                    end
`endif
                    else begin
                        pc_q <= next_pc;
                        if (fetch_cnt_q != '1) begin
                            fetch_cnt_q <= fetch_cnt_q + WL'(1);
                        end
                    end
                end
                // HALTED (and FAULT when present) are absorbing until reset;
                // all control inputs are ignored there.
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. ima is a plain slice of the PC, so it follows a PC change in
    // the same cycle and wraps inside the memory when no check is built.
    // ------------------------------------------------------------------
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.ima         = pc_q[IM_AW+1:2];
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_cnt   = fetch_cnt_q;

`ifdef PC_BOUNDS_CHECK_EN
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_scp.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_scp
// Purpose : self-checking bench for pc_fetch_scp. A driver applies one
//           directed vector per cycle on the falling edge and queues the
//           hand-computed state expected after the next rising edge; an
//           independent monitor samples the outputs shortly after each
//           rising edge and compares them with the head of the queue.
// Config  : honours PC_BOUNDS_CHECK_EN to pick the out-of-memory vectors.
// ---------------------------------------------------------------------------
module tb_pc_fetch_scp;

    localparam int WL    = 32;
    localparam int IM_AW = 6;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        halted;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_fetch_scp_if #(.WL(WL), .IM_AW(IM_AW)) bus ();

    pc_fetch_scp #(
        .WL       (WL),
        .IM_AW    (IM_AW),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares outputs against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] e_ima;
            e     = exp_q.pop_front();
            e_ima = {26'h0, e.pc[IM_AW+1:2]};
            check({e.name, ".pc"},          bus.pc,                 e.pc);
            check({e.name, ".pc_plus4"},    bus.pc_plus4,           e.pc + 32'd4);
            check({e.name, ".ima"},         {26'h0, bus.ima},       e_ima);
            check({e.name, ".fetch_valid"}, {31'h0, bus.fetch_valid}, {31'h0, e.fv});
            check({e.name, ".halted"},      {31'h0, bus.halted},    {31'h0, e.halted});
            check({e.name, ".fault"},       {31'h0, bus.fault},     {31'h0, e.fault});
            check({e.name, ".fetch_cnt"},   bus.fetch_cnt,          e.cnt);
        end
    end

    // Driver: apply one vector and queue what the DUT must show after the edge.
    task automatic step(input string name,
                        input logic r, input logic st, input logic hl,
                        input logic br, input logic [15:0] imm,
                        input logic jp, input logic [25:0] jt,
                        input logic j_r, input logic [31:0] ja,
                        input logic [31:0] e_pc, input logic e_fv,
                        input logic e_h, input logic e_f,
                        input logic [31:0] e_cnt);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.stall    = st;
        bus.halt     = hl;
        bus.branch   = br;
        bus.br_imm   = imm;
        bus.jump     = jp;
        bus.j_target = jt;
        bus.jr       = j_r;
        bus.jr_addr  = ja;
        e.name   = name;
        e.pc     = e_pc;
        e.fv     = e_fv;
        e.halted = e_h;
        e.fault  = e_f;
        e.cnt    = e_cnt;
        exp_q.push_back(e);
    endtask

    task automatic run(input string name, input logic [31:0] e_pc,
                       input logic [31:0] e_cnt);
        step(name, 0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, e_pc, 1, 0, 0, e_cnt);
    endtask

    task automatic do_reset(input string name);
        step(name, 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0, 1, 0, 0, 32'd0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.halt     = 1'b0;
        bus.branch   = 1'b0;
        bus.br_imm   = 16'h0;
        bus.jump     = 1'b0;
        bus.j_target = 26'h0;
        bus.jr       = 1'b0;
        bus.jr_addr  = 32'h0;

        // Reset then sequential fetch.
        do_reset("t1_reset");
        run("t1_seq1", 32'h04, 1);
        run("t1_seq2", 32'h08, 2);
        run("t1_seq3", 32'h0C, 3);
        run("t1_seq4", 32'h10, 4);
        run("t1_seq5", 32'h14, 5);

        // Branches from PC=0x10, positive and negative offsets.
        do_reset("t2_reset");
        run("t2_seq1", 32'h04, 1);
        run("t2_seq2", 32'h08, 2);
        run("t2_seq3", 32'h0C, 3);
        run("t2_seq4", 32'h10, 4);
        step("t2_br_pos", 0,0,0, 1,16'h0003, 0,26'h0, 0,32'h0,  32'h20, 1,0,0, 5);
        step("t2_jr_0x10",0,0,0, 0,16'h0000, 0,26'h0, 1,32'h10, 32'h10, 1,0,0, 6);
        step("t2_br_neg", 0,0,0, 1,16'hFFFE, 0,26'h0, 0,32'h0,  32'h0C, 1,0,0, 7);

        // Redirect priority.
        step("t3_jr_0x08",   0,0,0, 0,16'h0000, 0,26'h0,  1,32'h08, 32'h08, 1,0,0, 8);
        step("t3_jump_br",   0,0,0, 1,16'h0005, 1,26'h10, 0,32'h0,  32'h40, 1,0,0, 9);
        step("t3_jr_jump_br",0,0,0, 1,16'h0005, 1,26'h10, 1,32'h27, 32'h24, 1,0,0, 10);

        // Stall holds; halt beats stall; halted ignores inputs; reset recovers.
        step("t4_jr_0x14", 0,0,0, 0,16'h0000, 0,26'h0,  1,32'h14, 32'h14, 1,0,0, 11);
        step("t4_stall1",  0,1,0, 0,16'h0000, 0,26'h0,  0,32'h0,  32'h14, 1,0,0, 11);
        step("t4_stall2",  0,1,0, 1,16'h0007, 0,26'h0,  0,32'h0,  32'h14, 1,0,0, 11);
        step("t4_stall3",  0,1,0, 0,16'h0000, 1,26'h20, 0,32'h0,  32'h14, 1,0,0, 11);
        step("t4_halt_st", 0,1,1, 0,16'h0000, 1,26'h20, 0,32'h0,  32'h14, 0,1,0, 11);
        step("t4_hold_jr", 0,0,0, 0,16'h0000, 0,26'h0,  1,32'h80, 32'h14, 0,1,0, 11);
        step("t4_hold_run",0,0,0, 0,16'h0000, 0,26'h0,  0,32'h0,  32'h14, 0,1,0, 11);
        do_reset("t4_reset");
        run("t4_seq1", 32'h04, 1);

        // Reset during a jump discards the jump; halt beats jr.
        step("t6_rst_jump", 1,0,0, 0,16'h0000, 1,26'h30, 0,32'h0,  32'h00, 1,0,0, 0);
        step("t6_halt_jr",  0,0,1, 1,16'h0001, 0,26'h0,  1,32'h40, 32'h00, 0,1,0, 0);
        do_reset("t6_reset");
        step("t5_jr_0xfc",  0,0,0, 0,16'h0000, 0,26'h0,  1,32'hFC, 32'hFC, 1,0,0, 1);

`ifdef PC_BOUNDS_CHECK_EN
        // Leaving the instruction memory faults and holds the PC.
        step("t5_fault",      0,0,0, 0,16'h0000, 0,26'h0, 0,32'h0,    32'hFC, 0,0,1, 1);
        step("t5_fault_hold", 0,0,1, 0,16'h0000, 0,26'h0, 1,32'h10,   32'hFC, 0,0,1, 1);
        do_reset("t5_reset1");
        step("t5_halt_beats", 0,0,1, 0,16'h0000, 0,26'h0, 1,32'h1000, 32'h00, 0,1,0, 0);
        do_reset("t5_reset2");
        step("t5_jr_fault",   0,0,0, 0,16'h0000, 0,26'h0, 1,32'h1000, 32'h00, 0,0,1, 0);
        do_reset("t5_reset3");
`else
        // No check: PC leaves the memory, ima wraps, PC wraps mod 2^32.
        run("t5_wrap_im",  32'h100, 2);
        run("t5_wrap_im2", 32'h104, 3);
        step("t5_jr_top",  0,0,0, 0,16'h0000, 0,26'h0, 1,32'hFFFF_FFFF, 32'hFFFF_FFFC, 1,0,0, 4);
        run("t5_pc_wrap",  32'h0, 5);
        step("t5_br_m1",   0,0,0, 1,16'hFFFF, 0,26'h0, 0,32'h0, 32'h0,          1,0,0, 6);
        step("t5_br_m2",   0,0,0, 1,16'hFFFE, 0,26'h0, 0,32'h0, 32'hFFFF_FFFC, 1,0,0, 7);
`endif

        // Let the monitor consume the last expectation, then confirm nothing
        // was left unchecked.
        @(negedge clk);
        @(negedge clk);
        check("queue_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
